mcycle_ctrl: RTL and testbench

// - Multi-cycle MUL/DIV execution unit; sits between decode/operand fetch and writeback.
// - Accepts one operation per i_start, holds o_busy to stall the core, pulses o_done with results.
// - MUL runs a MUL_LATENCY-deep registered product pipeline.
// - DIV runs an iterative radix-2 restoring divider.

---
 rtl/mcycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mcycle_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MUL/DIV unit: MUL through a MUL_LATENCY-deep product pipeline, DIV through a radix-2 restoring divider.
// Latency from the start edge: MUL = MUL_LATENCY+1 edges, DIV = WIDTH+2 edges (divide-by-zero = 2 edges with MCYCLE_DIV0_FAST_EN).
// No queueing: i_start is sampled only in IDLE, o_busy stalls the core, and o_done pulses for one cycle with registered results.
module mcycle_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_mcycle_op,
    input  logic [WIDTH-1:0] i_operand1,
    input  logic [WIDTH-1:0] i_operand2,
    output logic [WIDTH-1:0] o_result1,
    output logic [WIDTH-1:0] o_result2,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic               mul_launch;
    logic               div_prep;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   div_rem, div_quo, div_dsr;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   res1_q, res2_q;

    // MUL datapath: extend to 2*WIDTH so one truncated product serves both signednesses.
    logic [2*WIDTH-1:0] mul_a, mul_b, mul_p, mul_out;
    logic               mul_out_vld;

    assign mul_a = op_q[0] ? {{WIDTH{1'b0}}, opa_q} : {{WIDTH{opa_q[WIDTH-1]}}, opa_q};
    assign mul_b = op_q[0] ? {{WIDTH{1'b0}}, opb_q} : {{WIDTH{opb_q[WIDTH-1]}}, opb_q};
    assign mul_p = mul_a * mul_b;

    generate
        if (MUL_LATENCY == 0) begin : g_mul_comb
            assign mul_out     = mul_p;
            assign mul_out_vld = mul_launch;
        end else begin : g_mul_pipe
            logic [2*WIDTH-1:0]   pipe_dat [MUL_LATENCY];
            logic [MUL_LATENCY-1:0] pipe_vld;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < MUL_LATENCY; i++) pipe_dat[i] <= '0;
                    pipe_vld <= '0;
                end else begin
                    pipe_dat[0] <= mul_p;
                    pipe_vld[0] <= mul_launch;
                    for (int i = 1; i < MUL_LATENCY; i++) begin
                        pipe_dat[i] <= pipe_dat[i-1];
                        pipe_vld[i] <= pipe_vld[i-1];
                    end
                end
            end

            assign mul_out     = pipe_dat[MUL_LATENCY-1];
            assign mul_out_vld = pipe_vld[MUL_LATENCY-1];
        end
    endgenerate

    // DIV datapath: unsigned restoring core on magnitudes, signs re-applied in DIV_FIX.
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   div_q_fix, div_r_fix;
    logic [WIDTH-1:0]   fin1, fin2;

    assign a_neg     = !op_q[0] && opa_q[WIDTH-1];
    assign b_neg     = !op_q[0] && opb_q[WIDTH-1];
    assign a_mag     = a_neg ? -opa_q : opa_q;
    assign b_mag     = b_neg ? -opb_q : opb_q;
    assign div_shift = {div_rem, div_quo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, div_dsr};

    always_comb begin
        div_q_fix = (a_neg ^ b_neg) ? -div_quo : div_quo;
        div_r_fix = a_neg ? -div_rem : div_rem;
        // Divide by zero is forced explicitly: the signed path would otherwise negate the all-ones quotient.
        if (opb_q == '0) begin
            div_q_fix = '1;
            div_r_fix = opa_q;
        end
    end

    always_comb begin
        fin1 = div_q_fix;
        fin2 = div_r_fix;
        if (state == MUL_WAIT) begin
            fin1 = mul_out[WIDTH-1:0];
            fin2 = mul_out[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = i_mcycle_op[1] ? DIV_RUN : MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mul_out_vld) state_nxt = DONE;
            end
            DIV_RUN: begin
`ifdef MCYCLE_DIV0_FAST_EN
                if (div_prep && opb_q == '0) state_nxt = DIV_FIX;
`endif
                if (!div_prep && cnt == CW'(WIDTH-1)) state_nxt = DIV_FIX;
            end
            DIV_FIX: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            op_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            mul_launch <= 1'b0;
            div_prep   <= 1'b0;
            cnt        <= '0;
            div_rem    <= '0;
            div_quo    <= '0;
            div_dsr    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res1_q     <= '0;
            res2_q     <= '0;
        end else begin
            state      <= state_nxt;
            mul_launch <= 1'b0;
            if (state == IDLE && i_start) begin
                op_q       <= i_mcycle_op;
                opa_q      <= i_operand1;
                opb_q      <= i_operand2;
                mul_launch <= !i_mcycle_op[1];
                div_prep   <= i_mcycle_op[1];
            end
            // First DIV_RUN cycle loads magnitudes; the following WIDTH cycles each retire one quotient bit.
            if (state == DIV_RUN) begin
                if (div_prep) begin
                    div_prep <= 1'b0;
                    div_rem  <= '0;
                    div_quo  <= a_mag;
                    div_dsr  <= b_mag;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                    if (!div_diff[WIDTH]) begin
                        div_rem <= div_diff[WIDTH-1:0];
                        div_quo <= {div_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        div_rem <= div_shift[WIDTH-1:0];
                        div_quo <= {div_quo[WIDTH-2:0], 1'b0};
                    end
                end
            end
            busy_q <= (state_nxt == MUL_WAIT) || (state_nxt == DIV_RUN) || (state_nxt == DIV_FIX);
            done_q <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                res1_q <= fin1;
                res2_q <= fin2;
            end
        end
    end

    assign o_result1 = res1_q;
    assign o_result2 = res2_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed and random checks of mcycle_ctrl (WIDTH=32, MUL_LATENCY=2): results, done latency, reset abort, start filtering.
module tb_mcycle_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [1:0]  i_mcycle_op;
    logic [31:0] i_operand1, i_operand2;
    logic [31:0] o_result1, o_result2;
    logic        o_busy, o_done;

    int total = 0;
    int bad   = 0;
    logic both_seen = 1'b0;

`ifdef MCYCLE_DIV0_FAST_EN
    localparam int DIV0_LAT = 2;
`else
    localparam int DIV0_LAT = 34;
`endif

    mcycle_ctrl #(.WIDTH(32), .MUL_LATENCY(2)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_mcycle_op (i_mcycle_op),
        .i_operand1  (i_operand1),
        .i_operand2  (i_operand2),
        .o_result1   (o_result1),
        .o_result2   (o_result2),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) if (o_busy && o_done) both_seen = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {remainder/high, quotient/low}.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sq, sr;
        case (op)
            2'b00: p = longint'($signed(a)) * longint'($signed(b));
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
                else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    p  = {sr, sq};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the first IDLE edge following o_done.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e1, input logic [31:0] e2, input int elat);
        int lat = 0;
        i_mcycle_op = op;
        i_operand1  = a;
        i_operand2  = b;
        i_start     = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        while (!o_done && lat < 200) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".r1"}, {32'b0, o_result1}, {32'b0, e1});
        check({tag, ".r2"}, {32'b0, o_result2}, {32'b0, e2});
        @(posedge i_clk); #1;
    endtask

    initial begin
        int lat;
        int ndone;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] e;

        i_rst_n = 1'b0; i_start = 1'b0; i_mcycle_op = 2'b00;
        i_operand1 = '0; i_operand2 = '0;
        #12;
        check("rst.busy", {63'b0, o_busy}, 64'd0);
        check("rst.done", {63'b0, o_done}, 64'd0);
        check("rst.r1", {32'b0, o_result1}, 64'd0);
        check("rst.r2", {32'b0, o_result2}, 64'd0);
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        run_op("mul_s", 2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'hFFFFFFFF, 3);
        run_op("mul_u", 2'b01, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h00000001, 3);
        run_op("div_s", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 34);
        run_op("div_u", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 34);
        run_op("div0_u", 2'b11, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, DIV0_LAT);
        run_op("div0_s", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, DIV0_LAT);

        // i_start held high through a DIV with changing operands, then a MUL taken back-to-back.
        i_mcycle_op = 2'b11; i_operand1 = 32'd100; i_operand2 = 32'd7; i_start = 1'b1;
        @(posedge i_clk); #1;
        check("hold.busy", {63'b0, o_busy}, 64'd1);
        i_mcycle_op = 2'b01; i_operand1 = 32'd3; i_operand2 = 32'd5;
        lat = 0;
        while (!o_done && lat < 200) begin @(posedge i_clk); #1; lat++; end
        check("hold.lat", 64'(lat), 64'd34);
        check("hold.q", {32'b0, o_result1}, 64'd14);
        check("hold.r", {32'b0, o_result2}, 64'd2);
        lat = 0;
        @(posedge i_clk); #1;
        lat++;
        while (!o_done && lat < 200) begin @(posedge i_clk); #1; lat++; end
        i_start = 1'b0;
        check("b2b.lat", 64'(lat), 64'd5);
        check("b2b.lo", {32'b0, o_result1}, 64'd15);
        check("b2b.hi", {32'b0, o_result2}, 64'd0);
        @(posedge i_clk); #1;

        // Reset asserted around divider iteration 10 aborts the operation.
        i_mcycle_op = 2'b10; i_operand1 = 32'hFFFFFFF9; i_operand2 = 32'd2; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (11) begin @(posedge i_clk); #1; end
        i_rst_n = 1'b0;
        #1;
        check("abort.busy", {63'b0, o_busy}, 64'd0);
        check("abort.done", {63'b0, o_done}, 64'd0);
        check("abort.r1", {32'b0, o_result1}, 64'd0);
        check("abort.r2", {32'b0, o_result2}, 64'd0);
        @(negedge i_clk); i_rst_n = 1'b1;
        ndone = 0;
        repeat (50) begin @(posedge i_clk); #1; if (o_done) ndone++; end
        check("abort.stray", 64'(ndone), 64'd0);

        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h80000000;
            e = ref_model(op, a, b);
            run_op($sformatf("rnd%0d.op%0d", n, op), op, a, b, e[31:0], e[63:32],
                   op[1] ? ((b == 0) ? DIV0_LAT : 34) : 3);
        end

        check("busy_and_done", {63'b0, both_seen}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
